// File: rtl/rr_arb_mux_nway.sv
// N-channel W-bit round-robin arbitrated mux with beat locking and a registered output stage.
// Define RR_ARB_MUX_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module rr_arb_mux_nway #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned SELW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_last,
  input  logic            out_ready
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] lock_q, lock_d;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  logic            out_valid_d;
  logic [W-1:0]    out_data_d;
  logic [SELW-1:0] out_sel_d;
  logic            out_last_d;

  logic            gnt_vld_c;
  logic [SELW-1:0] gnt_idx_c;
  logic [SELW-1:0] cand_c;
  logic            load_en_c;
  logic            xfer_c;

  // Grant selection; reverse scan so the earliest candidate in search order wins.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    cand_c    = '0;
    if (state_q == LOCKED) begin
      gnt_vld_c = in_valid[lock_q];
      gnt_idx_c = lock_q;
    end else begin
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
      for (int k = int'(N) - 1; k >= 0; k--) begin
        cand_c = SELW'(k);
        if (in_valid[cand_c]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = cand_c;
        end
      end
`else
      for (int k = int'(N); k >= 1; k--) begin
        cand_c = SELW'((int'(rr_ptr_q) + k) % int'(N));
        if (in_valid[cand_c]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = cand_c;
        end
      end
`endif
    end
  end

  // Handshake, output-stage load and arbitration state update.
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sel_d   = out_sel;
    out_last_d  = out_last;
    in_ready    = '0;
    load_en_c   = ~out_valid | out_ready;
    xfer_c      = gnt_vld_c & load_en_c;

    if (xfer_c) begin
      in_ready[gnt_idx_c] = 1'b1;
      out_valid_d         = 1'b1;
      out_sel_d           = gnt_idx_c;
      out_last_d          = in_last[gnt_idx_c];
      for (int i = 0; i < int'(N); i++) begin
        if (gnt_idx_c == SELW'(i)) out_data_d = in_data[i*W +: W];
      end
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
      rr_ptr_d = gnt_idx_c;
`endif
      if (in_last[gnt_idx_c]) begin
        state_d = ARB;
      end else begin
        state_d = LOCKED;
        lock_d  = gnt_idx_c;
      end
    end else if (load_en_c) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB;
      lock_q    <= '0;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
      rr_ptr_q  <= SELW'(N - 1);
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sel   <= out_sel_d;
      out_last  <= out_last_d;
    end
  end

endmodule

// File: doc/rr_arb_mux_nway.md
Name: rr_arb_mux_nway

Overview:
- Parametrised N-channel, W-bit arbitrated multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the fixed-width combinational muxes. Adds round-robin arbitration, multi-beat grant locking and a registered output stage.
- Sits where several producers share one consumer, e.g. fetch, LSU and page-walker requests funnelling into a single memory/bus port.

Parameters:
- N, 4, number of input channels (2..16).
- W, 32, data width per channel (1..128).
- SELW, 2, width of channel index; must equal ceil(log2(N)).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel request valid.
- in_data  input  N*W  channel i data at bits [i*W+W-1 : i*W].
- in_last  input  N  per-channel last-beat flag; 0 requests grant lock for the next beat.
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered selected data.
- out_sel  output  SELW  index of channel that produced out_data.
- out_last  output  1  registered in_last of that beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, out_last=0, state=ARB, rr_ptr=N-1, lock_idx=0. A reset mid-transfer drops any held beat and clears the lock.
- Output register is a single entry. load_en = ~out_valid | out_ready. This gives one beat per cycle sustained and one-cycle latency from input accept to out_valid.
- Grant (combinational from registered state and in_valid):
  - ARB state: grant goes to the first valid channel searching rr_ptr+1, rr_ptr+2, ... modulo N, wrapping N-1 -> 0.
  - LOCKED state: grant goes to lock_idx only, and only if in_valid[lock_idx]. Other channels are starved; there is no timeout.
- in_ready[i] = grant[i] & load_en. in_ready never depends on in_data.
- Transfer on channel g when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data[g], out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - rr_ptr <= g.
  - If in_last[g]=0: state <= LOCKED, lock_idx <= g.
  - If in_last[g]=1: state <= ARB.
- No transfer while load_en=1: out_valid <= 0 if out_ready. Output fields otherwise hold.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready are 0 and output fields are stable. Arbitration state does not advance.
- Single requester: granted every cycle regardless of rr_ptr.
- No requester: in_ready=0; state, rr_ptr and lock_idx are unchanged.
- A LOCKED channel that deasserts in_valid holds the lock; the mux idles until it returns.
- Input data is not required to be held once accepted. The registered copy is authoritative.

Optional Feature:
- Macro RR_ARB_MUX_FIXED_PRIO_EN.
- When defined: ARB-state grant is fixed priority, lowest valid index wins, and rr_ptr is removed. Locking, handshakes and the output register are unchanged.
- When undefined: round-robin as above.

Test Plan:
- N=4, W=32. After reset, in_valid=4'b1111, all in_last=1, out_ready=1 held. Expect out_sel sequence 0,1,2,3,0 on consecutive cycles, first out_valid one cycle after first accept; out_data matches in_data of each channel (e.g. 0xA0,0xA1,0xA2,0xA3).
- Channel 2 sends 3 beats with in_last=0,0,1 while channels 0,1 are valid. Expect out_sel=2 for three consecutive beats, then channel 3 (or next valid after 2) granted; in_ready[0]=in_ready[1]=0 during the lock.
- out_valid=1 with out_ready=0 for 5 cycles while all channels are valid. Expect in_ready=0, out_data and out_sel frozen. Release out_ready: the next beat follows immediately, with no bubble.
- Only channel 1 valid, rr_ptr=1. Expect channel 1 accepted every cycle, out_sel=1 each beat.
- Assert reset mid-lock (channel 3, beat 2 of 4). Expect out_valid=0 within the same cycle and state=ARB; after release with all channels valid, the first grant goes to channel 0.
- RR_ARB_MUX_FIXED_PRIO_EN defined, in_valid=4'b1010 for 4 cycles, in_last=1. Expect out_sel=1 on every beat; channel 3 is never granted.
